// File: rtl/cnt_pkg.sv
// Shared definitions for the counter event monitor: event codes and the
// default counter width.
package cnt_pkg;

  localparam int CNT_WIDTH = 8;

  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_WRAP_UP = 2'b01;
  localparam logic [1:0] EVT_WRAP_DN = 2'b10;
  localparam logic [1:0] EVT_MATCH   = 2'b11;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO with a separate occupancy counter. A push while full
// is only accepted when a pop frees a slot in the same cycle.
module evt_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// Watches the up/down counter output for wrap-arounds and compare matches and
// queues each event with a count snapshot for the control/status logic.
module count_event_monitor
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             up_down,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             evt_ready,
  input  logic             clear_ovf,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_count,
  output logic             overflow
);

  // Handshake: the head event transfers on a posedge where evt_valid &&
  // evt_ready; evt_code/evt_count hold steady until that transfer.

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       code_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;
  logic [WIDTH+1:0] fifo_dout;

  // Wrap outranks match, so a coincident match is silently discarded.
  always_comb begin
    code_d = EVT_NONE;
    if (enable && prev_valid_q) begin
      if (up_down && (prev_q == ALL_ONES) && (count_in == '0))
        code_d = EVT_WRAP_UP;
      else if (!up_down && (prev_q == '0) && (count_in == ALL_ONES))
        code_d = EVT_WRAP_DN;
      else if ((count_in == cmp_value) && (count_in != prev_q))
        code_d = EVT_MATCH;
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign push = (code_d != EVT_NONE);
  assign drop = push && fifo_full && !pop;

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = enable;
    if (enable) prev_d = count_in;
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  evt_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   ({code_d, count_in}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = fifo_dout[WIDTH+1:WIDTH];
  assign evt_count = fifo_dout[WIDTH-1:0];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed vector tables, hand sequences for
// FIFO fill / enable / mid-run reset, then random stimulus against a queue model.
module tb_count_event_monitor;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << W) - 1;

  logic         clk, reset, enable, up_down, evt_ready, clear_ovf;
  logic [W-1:0] count_in, cmp_value;
  logic         evt_valid, overflow;
  logic [1:0]   evt_code;
  logic [W-1:0] evt_count;

  int checks = 0;
  int errors = 0;

  count_event_monitor #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .count_in  (count_in),
    .up_down   (up_down),
    .cmp_value (cmp_value),
    .evt_ready (evt_ready),
    .clear_ovf (clear_ovf),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en, ud, rdy, clr;
    logic [W-1:0] cnt, cmp;
    logic         ev;
    logic [1:0]   ec;
    logic [W-1:0] ecnt;
    logic         eo;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic vec_t mk(logic en, logic ud, int cnt, int cmp, logic rdy, logic clr,
                              logic ev, logic [1:0] ec, int ecnt, logic eo);
    vec_t v;
    v.en = en; v.ud = ud; v.cnt = W'(cnt); v.cmp = W'(cmp); v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ec = ec; v.ecnt = W'(ecnt); v.eo = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: apply one vector across one posedge, then compare outputs.
  task automatic apply(vec_t v, string tag);
    enable = v.en; up_down = v.ud; count_in = v.cnt; cmp_value = v.cmp;
    evt_ready = v.rdy; clear_ovf = v.clr;
    step();
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v.ev));
    chk({tag, ".ovf"}, 32'(overflow), 32'(v.eo));
    if (v.ev) begin
      chk({tag, ".code"}, 32'(evt_code), 32'(v.ec));
      chk({tag, ".count"}, 32'(evt_count), 32'(v.ecnt));
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, ".valid"}, 32'(evt_valid), 0);
    chk({tag, ".code"}, 32'(evt_code), 0);
    chk({tag, ".count"}, 32'(evt_count), 0);
    chk({tag, ".ovf"}, 32'(overflow), 0);
  endtask

  // Scoreboard / reference model
  logic [W+1:0] exp_q[$];
  int           m_prev;
  bit           m_pv;
  bit           m_ovf;

  task automatic model_clear();
    exp_q.delete();
    m_prev = 0; m_pv = 0; m_ovf = 0;
  endtask

  task automatic model_cycle();
    logic [1:0] code;
    int c, p;
    bit dropped;
    c = int'(count_in); p = m_prev; code = 2'b00; dropped = 0;
    if (enable && m_pv) begin
      if (up_down && p == MAXV && c == 0)                code = 2'b01;
      else if (!up_down && p == 0 && c == MAXV)          code = 2'b10;
      else if (c == int'(cmp_value) && c != p)           code = 2'b11;
    end
    if (evt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (code != 2'b00) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({code, W'(c)});
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    if (enable) begin m_prev = c; m_pv = 1; end
    else m_pv = 0;
  endtask

  task automatic model_compare(int i);
    string t;
    t = $sformatf("rand%0d", i);
    chk({t, ".valid"}, 32'(evt_valid), 32'(exp_q.size() > 0));
    chk({t, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (exp_q.size() > 0) begin
      chk({t, ".code"}, 32'(evt_code), 32'(exp_q[0][W+1:W]));
      chk({t, ".count"}, 32'(evt_count), 32'(exp_q[0][W-1:0]));
    end
  endtask

  initial begin
    int cnt_r, rdy_pct, r;

    reset = 1'b0; enable = 1'b0; up_down = 1'b1; count_in = '0; cmp_value = '0;
    evt_ready = 1'b0; clear_ovf = 1'b0;

    // Directed: wrap up, down wrap with match, held value and wrap priority
    tbl_a.push_back(mk(1,1,253,100,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,254,100,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,255,100,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,  0,100,1,0, 1,2'b01,0,0));
    tbl_a.push_back(mk(1,1,  0,100,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,0,  2,  1,0,0, 0,0,0,0));
    tbl_a.push_back(mk(1,0,  1,  1,0,0, 1,2'b11,1,0));
    tbl_a.push_back(mk(1,0,  0,  1,0,0, 1,2'b11,1,0));
    tbl_a.push_back(mk(1,0,255,  1,0,0, 1,2'b11,1,0));
    tbl_a.push_back(mk(1,0,255,  1,1,0, 1,2'b10,255,0));
    tbl_a.push_back(mk(1,0,255,  1,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,  5,  5,1,0, 1,2'b11,5,0));
    tbl_a.push_back(mk(1,1,  5,  5,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,  5,  5,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,  5,  5,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,255,  0,1,0, 0,0,0,0));
    tbl_a.push_back(mk(1,1,  0,  0,1,0, 1,2'b01,0,0));
    tbl_a.push_back(mk(1,1,  0,  0,1,0, 0,0,0,0));

    // Enable gating: disabled wrap and first re-enabled sample stay silent
    tbl_b.push_back(mk(1,1,254,0,1,0, 0,0,0,0));
    tbl_b.push_back(mk(1,1,255,0,1,0, 0,0,0,0));
    tbl_b.push_back(mk(0,1,  0,0,1,0, 0,0,0,0));
    tbl_b.push_back(mk(1,1,  0,0,1,0, 0,0,0,0));
    tbl_b.push_back(mk(1,1,  1,1,1,0, 1,2'b11,1,0));
    tbl_b.push_back(mk(1,1,  1,1,1,0, 0,0,0,0));

    #3 chk_idle("rst_a");
    #10 chk_idle("rst_b");
    #7 reset = 1'b1;
    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("dir%0d", i));

    // FIFO fill: four matches kept, fifth dropped
    for (int k = 0; k < 5; k++)
      apply(mk(1,1,10+k,10+k,0,0, 1,2'b11,10,(k == 4)), $sformatf("fill%0d", k));
    apply(mk(1,1,14,99,0,1, 1,2'b11,10,0), "clr_ovf");
    apply(mk(1,1,15,15,1,0, 1,2'b11,11,0), "full_push_pop");
    apply(mk(1,1,15,99,1,0, 1,2'b11,12,0), "drain0");
    apply(mk(1,1,15,99,1,0, 1,2'b11,13,0), "drain1");
    apply(mk(1,1,15,99,1,0, 1,2'b11,15,0), "drain2");
    apply(mk(1,1,15,99,1,0, 0,0,0,0), "drain3");

    // Drop coinciding with clear: set wins
    for (int k = 0; k < 4; k++)
      apply(mk(1,1,20+k,20+k,0,0, 1,2'b11,20,0), $sformatf("refill%0d", k));
    apply(mk(1,1,24,24,0,1, 1,2'b11,20,1), "drop_vs_clr");
    apply(mk(1,1,24,99,1,0, 1,2'b11,21,1), "pop_to3");

    // Mid-operation reset with three queued events
    enable = 1'b1; evt_ready = 1'b0;
    #2 reset = 1'b0;
    #1 chk_idle("mid_rst");
    step();
    chk_idle("mid_rst_hold");
    reset = 1'b1;
    foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("en%0d", i));

    // Random stimulus against the queue model
    reset = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    cnt_r = 0; rdy_pct = 50; up_down = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) rdy_pct = (i / 200) % 3 == 0 ? 15 : ((i / 200) % 3 == 1 ? 90 : 50);
      r = $urandom_range(0, 9);
      if (r < 6) cnt_r = up_down ? (cnt_r + 1) & MAXV : (cnt_r + MAXV) & MAXV;
      else if (r == 9) begin
        case ($urandom_range(0, 4))
          0: cnt_r = 0;
          1: cnt_r = MAXV;
          2: cnt_r = MAXV - 1;
          3: cnt_r = 1;
          default: cnt_r = $urandom_range(0, MAXV);
        endcase
      end
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      count_in  = W'(cnt_r);
      r = $urandom_range(0, 3);
      cmp_value = (r == 0) ? W'(cnt_r) : (r == 1) ? W'((cnt_r + 1) & MAXV) :
                  (r == 2) ? W'(0) : W'($urandom_range(0, MAXV));
      enable    = ($urandom_range(0, 15) != 0);
      evt_ready = ($urandom_range(0, 99) < rdy_pct);
      clear_ovf = ($urandom_range(0, 19) == 0);
      if (i == 1000) begin
        #2 reset = 1'b0;
        model_clear();
        #1 chk("rand_rst.valid", 32'(evt_valid), 0);
        chk("rand_rst.ovf", 32'(overflow), 0);
        step();
        reset = 1'b1;
      end else begin
        model_cycle();
        step();
        model_compare(i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 8-bit up/down counter output.
- Samples the counter value every clock and detects two kinds of event:
  - wrap-around in either direction;
  - a match against a programmable compare value.
- Queues each event, with a snapshot of the count value, in a small FIFO.
- Presents queued events on a valid/ready interface to the control/status logic.

Parameters:
- WIDTH, 8, counter value width; must equal the counter output width.
- DEPTH, 4, event FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable  input  1  1 = monitor active; 0 = no detection, history invalidated.
- count_in  input  WIDTH  counter output value, sampled on posedge clk.
- up_down  input  1  counter direction, same value driven to the counter; 1 = up, 0 = down.
- cmp_value  input  WIDTH  match compare value; may change at any time; used as sampled each cycle.
- evt_ready  input  1  consumer accepts the head event when evt_valid && evt_ready at posedge.
- clear_ovf  input  1  synchronous clear of the sticky overflow flag.
- evt_valid  output  1  FIFO non-empty.
- evt_code  output  2  head event code.
- evt_count  output  WIDTH  count_in snapshot taken when the head event was detected.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset = 0, async):
  - FIFO emptied; evt_valid = 0, evt_code = 0, evt_count = 0, overflow = 0.
  - prev_q = 0, prev_valid = 0.
  - Takes effect mid-operation; queued events are lost.
- History:
  - Each posedge with enable = 1: prev_q <= count_in, prev_valid <= 1.
  - enable = 0: prev_valid <= 0, no detection.
  - First enabled sample after reset or re-enable never produces an event.
- Detection (combinational, on the cycle's count_in vs prev_q, only when enable && prev_valid):
  - WRAP_UP, code 2'b01: up_down = 1, prev_q = all-ones, count_in = 0.
  - WRAP_DN, code 2'b10: up_down = 0, prev_q = 0, count_in = all-ones.
  - MATCH, code 2'b11: count_in == cmp_value and count_in != prev_q. A held value does not re-trigger.
  - Priority: wrap over match. At most one event per cycle; a coincident match is discarded (e.g. cmp_value = 0 with an up-wrap logs WRAP_UP only).
  - Code 2'b00 is reserved and never queued.
- Latency:
  - Event detected on the sample at posedge N is written at posedge N.
  - If the FIFO was empty, evt_valid = 1 after posedge N, with evt_code/evt_count valid.
  - evt_code/evt_count are registered FIFO head outputs, stable while evt_valid && !evt_ready.
- FIFO:
  - Push on event; pop on evt_valid && evt_ready.
  - Full + event + pop in the same cycle: both happen, nothing is lost.
  - Full + event, no pop: event dropped, overflow <= 1, occupancy unchanged.
  - Empty + pop request: ignored, since evt_valid = 0.
  - Pointers wrap modulo DEPTH; separate occupancy counter of width log2(DEPTH)+1.
- Overflow:
  - clear_ovf = 1 clears overflow.
  - If a drop occurs in the same cycle as clear_ovf, set wins and overflow stays 1.
- Width rules:
  - All-ones = {WIDTH{1'b1}}.
  - Comparisons are unsigned equality only; no arithmetic on count values.
- up_down toggling mid-stream: each cycle's detection uses only that cycle's up_down value.

Decomposition:
- Shared package cnt_pkg holds:
  - event code constants: EVT_NONE = 2'b00, EVT_WRAP_UP = 2'b01, EVT_WRAP_DN = 2'b10, EVT_MATCH = 2'b11;
  - default WIDTH = 8.
- One sub-module: evt_fifo.
  - Synchronous FIFO, parameterised on data width (2 + WIDTH) and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low reset.
- Top level contains only history registers, detect logic and overflow flag.

Test Plan:
- Reset / idle check:
  - Stimulus: reset = 0 for 20 time units, then reset = 1, enable = 1, up_down = 1; count_in stepping 253, 254, 255, 0; evt_ready = 1.
  - Required: during reset all outputs are 0; one WRAP_UP event with evt_count = 0, evt_valid high for exactly one cycle after the 255→0 sample.
- Down wrap plus match:
  - Stimulus: up_down = 0, count_in stepping 2, 1, 0, 255; cmp_value = 1.
  - Required: MATCH with evt_count = 1, then WRAP_DN with evt_count = 255, in that order.
- Held value and wrap priority:
  - Stimulus: count_in held at 5 for 4 cycles with cmp_value = 5; then cmp_value = 0 and an up-wrap 255→0.
  - Required: exactly one MATCH (evt_count = 5), then a single WRAP_UP with no MATCH entry.
- FIFO fill and overflow:
  - Stimulus: evt_ready = 0; generate 5 matches (cmp_value retargeted each cycle) with DEPTH = 4.
  - Required: 4 entries kept in order, overflow = 1 after the 5th; clear_ovf pulse → overflow = 0; full + push + pop in the same cycle keeps occupancy 4 and sets no overflow.
- Enable and mid-operation reset:
  - Stimulus: enable = 0 while count_in goes 255→0, then enable = 1 at count_in = 0; separately, assert reset with 3 events queued.
  - Required: no event for the disabled wrap and no event on the first re-enabled sample; the reset immediately drops evt_valid to 0 and empties the FIFO.
